// File: rtl/aes_mm_pkg.sv
// aes_mm_pkg: register map of the AES register-mapped slave and the initiator FSM encoding.
// Shared by aes_mm_master and aes_mm_read_beat.
package aes_mm_pkg;

    // Slave word addresses
    localparam logic [3:0] ADDR_IN0       = 4'd0;
    localparam logic [3:0] ADDR_IN1       = 4'd1;
    localparam logic [3:0] ADDR_IN2       = 4'd2;
    localparam logic [3:0] ADDR_IN3       = 4'd3;
    localparam logic [3:0] ADDR_LOAD_DATA = 4'd4;
    localparam logic [3:0] ADDR_LOAD_KEY  = 4'd5;
    localparam logic [3:0] ADDR_RES0      = 4'd6;
    localparam logic [3:0] ADDR_RES1      = 4'd7;
    localparam logic [3:0] ADDR_RES2      = 4'd8;
    localparam logic [3:0] ADDR_RES3      = 4'd9;
    localparam logic [3:0] ADDR_STATUS    = 4'd10;
    localparam logic [3:0] ADDR_RB0       = 4'd11;
    localparam logic [3:0] ADDR_RB1       = 4'd12;
    localparam logic [3:0] ADDR_RB2       = 4'd13;
    localparam logic [3:0] ADDR_RB3       = 4'd14;

    typedef enum logic [3:0] {
        StIdle,
        StWrWord,
        StReadBack,
        StStrobe,
        StWait,
        StPoll,
        StResRd,
        StDone,
        StErr
    } mmState_e;

    // Word idx of a block, most significant word first (idx 0 = [127:96])
    function automatic logic [31:0] blockWord(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_mm_read_beat.sv
// aes_mm_read_beat: one bus read against the slave's registered read port.
// A one-cycle iIssue drives the read strobe; the slave answers in the following cycle, during
// which oValid is high and oWord carries the slave word for the caller to sample at its end.
module aes_mm_read_beat
    import aes_mm_pkg::*;
(
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iIssue,
    output logic        oRead_n,
    input  logic [31:0] iData,
    output logic        oValid,
    output logic [31:0] oWord
);

    logic pending;

    // Remember that a strobe went out so the next cycle is flagged as the data cycle
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            pending <= 1'b0;
        end else begin
            pending <= iIssue;
        end
    end

    // iIssue is a register in the caller, so the strobe stays glitch-free
    assign oRead_n = ~iIssue;
    assign oValid  = pending;
    assign oWord   = iData;

endmodule

// File: rtl/aes_mm_master.sv
// aes_mm_master: bus initiator for the AES register-mapped slave. Writes a 128-bit key or
// plaintext over the 32-bit CS/WR/RD bus, fires Load_Key/Load_Data, polls status and reads back
// the ciphertext.
// Build option AES_MM_READBACK_EN: the written block is read back via RB0..RB3 and compared
// before any load strobe; a mismatch aborts with oError.
module aes_mm_master
    import aes_mm_pkg::*;
#(
    parameter int unsigned AES_LATENCY = 12,
    parameter int unsigned POLL_LIMIT  = 64
) (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iStart,
    input  logic         iMode,
    input  logic [127:0] iBlock,
    output logic         oBusy,
    output logic         oDone,
    output logic         oError,
    output logic [127:0] oResult,
    output logic         oChipSelect_n,
    output logic         oWrite_n,
    output logic         oRead_n,
    output logic [3:0]   oAddress,
    output logic [31:0]  oData,
    input  logic [31:0]  iData
);

    localparam int unsigned WAIT_W = $clog2(AES_LATENCY + 1);
    localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);

    mmState_e          state;
    logic [127:0]      blockQ;
    logic              modeQ;
    logic [2:0]        beatCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic [POLL_W-1:0] pollCnt;
    logic              wrN;
    logic              rdIssue;
    logic [3:0]        addrQ;
    logic [31:0]       dataQ;
    logic              busy;
    logic              done;
    logic              error;
    logic [127:0]      result;
    logic [95:0]       resAccum;
    logic              rdN;
    logic              rdValid;
    logic [31:0]       rdWord;

    aes_mm_read_beat uReadBeat (
        .iClk    (iClk),
        .iReset_n(iReset_n),
        .iIssue  (rdIssue),
        .oRead_n (rdN),
        .iData   (iData),
        .oValid  (rdValid),
        .oWord   (rdWord)
    );

    // Sequencer: every bus strobe and status output is a register set one cycle ahead
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state    <= StIdle;
            blockQ   <= '0;
            modeQ    <= 1'b0;
            beatCnt  <= '0;
            waitCnt  <= '0;
            pollCnt  <= '0;
            wrN      <= 1'b1;
            rdIssue  <= 1'b0;
            addrQ    <= '0;
            dataQ    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            result   <= '0;
            resAccum <= '0;
        end else begin
            // Strobes and pulses last a single cycle unless re-armed below
            wrN     <= 1'b1;
            rdIssue <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            case (state)
                StIdle: begin
                    if (iStart) begin
                        blockQ  <= iBlock;
                        modeQ   <= iMode;
                        busy    <= 1'b1;
                        wrN     <= 1'b0;
                        addrQ   <= ADDR_IN0;
                        dataQ   <= iBlock[127:96];
                        beatCnt <= 3'd1;
                        state   <= StWrWord;
                    end
                end
                StWrWord: begin
                    if (beatCnt == 3'd4) begin
`ifdef AES_MM_READBACK_EN
                        rdIssue <= 1'b1;
                        addrQ   <= ADDR_RB0;
                        beatCnt <= 3'd0;
                        state   <= StReadBack;
`else
                        wrN   <= 1'b0;
                        addrQ <= modeQ ? ADDR_LOAD_DATA : ADDR_LOAD_KEY;
                        dataQ <= '0;
                        state <= StStrobe;
`endif
                    end else begin
                        wrN     <= 1'b0;
                        addrQ   <= addrQ + 4'd1;
                        dataQ   <= blockWord(blockQ, beatCnt[1:0]);
                        beatCnt <= beatCnt + 3'd1;
                    end
                end
`ifdef AES_MM_READBACK_EN
                StReadBack: begin
                    if (rdValid) begin
                        if (rdWord != blockWord(blockQ, beatCnt[1:0])) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= StErr;
                        end else if (beatCnt == 3'd3) begin
                            wrN   <= 1'b0;
                            addrQ <= modeQ ? ADDR_LOAD_DATA : ADDR_LOAD_KEY;
                            dataQ <= '0;
                            state <= StStrobe;
                        end else begin
                            rdIssue <= 1'b1;
                            addrQ   <= addrQ + 4'd1;
                            beatCnt <= beatCnt + 3'd1;
                        end
                    end
                end
`endif
                StStrobe: begin
                    if (!modeQ) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else begin
                        waitCnt <= '0;
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (waitCnt == WAIT_W'(AES_LATENCY - 1)) begin
                        rdIssue <= 1'b1;
                        addrQ   <= ADDR_STATUS;
                        pollCnt <= '0;
                        state   <= StPoll;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                StPoll: begin
                    if (rdValid) begin
                        if (rdWord[0]) begin
                            rdIssue <= 1'b1;
                            addrQ   <= ADDR_RES0;
                            beatCnt <= 3'd0;
                            state   <= StResRd;
                        end else if (pollCnt == POLL_W'(POLL_LIMIT - 1)) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= StErr;
                        end else begin
                            pollCnt <= pollCnt + 1'b1;
                            rdIssue <= 1'b1;
                        end
                    end
                end
                StResRd: begin
                    if (rdValid) begin
                        if (beatCnt == 3'd3) begin
                            // Publish all four words together so oResult never shows a mix
                            result <= {resAccum, rdWord};
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= StDone;
                        end else begin
                            resAccum <= {resAccum[63:0], rdWord};
                            rdIssue  <= 1'b1;
                            addrQ    <= addrQ + 4'd1;
                            beatCnt  <= beatCnt + 3'd1;
                        end
                    end
                end
                StDone:  state <= StIdle;
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign oBusy         = busy;
    assign oDone         = done;
    assign oError        = error;
    assign oResult       = result;
    assign oWrite_n      = wrN;
    assign oRead_n       = rdN;
    assign oChipSelect_n = wrN & rdN;
    assign oAddress      = addrQ;
    assign oData         = dataQ;

endmodule
